pipeline_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It drives the stall (hold) and flush (bubble-insert) controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves load-use hazards, taken-branch redirects and data-memory wait states, with a watchdog that halts the core on a hung memory. Flushing a register means loading a bubble: reg_write, mem_write and branch controls are forced to 0.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the core's pipeline sequencing control.
package cpu_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_HALT     = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction reading the register a load in EX is about to write.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use, branch redirect, memory wait, watchdog halt.
// Define PIPELINE_CTRL_PERF_EN to add the stall_cnt_o / flush_cnt_o performance counters.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic                  halted_o,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
`endif
  output logic [1:0]            state_o
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

  ctrl_state_e state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        halted_q, halted_d;
  logic        memwait;
  logic        load_use;
  logic        halt_now;
  logic        branch_act;

  hazard_detect u_hazard_detect (
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd_addr   (ex_rd_addr),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .load_use     (load_use)
  );

  assign memwait = mem_req && !mem_ready;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    halted_d   = halted_q;
    halt_now   = 1'b0;
    case (state_q)
      CTRL_RUN: begin
        wait_cnt_d = '0;
        if (memwait) state_d = CTRL_MEM_WAIT;
      end
      CTRL_MEM_WAIT: begin
        if (!memwait) begin
          state_d = CTRL_RUN;
        end else begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d  = CTRL_HALT;
            halted_d = 1'b1;
          end
          if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      // The unused encoding behaves exactly like HALT.
      default: begin
        state_d  = CTRL_HALT;
        halted_d = 1'b1;
        halt_now = 1'b1;
      end
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    branch_act   = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (halt_now || memwait) begin
      // A pending branch stays in EX while frozen and is taken on the release cycle.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      branch_act  = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CTRL_RUN;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
    end
  end

  assign halted_o = halted_q;
  assign state_o  = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pc_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, branch_act};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl (WAIT_LIMIT=4 so the watchdog fires quickly).
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush, halted_o;
  logic [1:0] state_o;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd_addr      (ex_rd_addr),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_flush    (mem_wb_flush),
    .halted_o        (halted_o),
`ifdef PIPELINE_CTRL_PERF_EN
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
`endif
    .state_o         (state_o)
  );

  // Output bundle order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_BR    = 7'b0010100;
  localparam logic [6:0] O_FRZ   = 7'b1101011;
  localparam logic [6:0] O_RST   = 7'b0010101;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       rs1_u, rs2_u;
    logic [4:0] rd;
    logic       rw, mr, br, mreq, mrdy;
    logic [6:0] exp_o;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    id_rs1_addr     = v.rs1;
    id_rs2_addr     = v.rs2;
    id_rs1_used     = v.rs1_u;
    id_rs2_used     = v.rs2_u;
    ex_rd_addr      = v.rd;
    ex_reg_write    = v.rw;
    ex_mem_read     = v.mr;
    ex_branch_taken = v.br;
    mem_req         = v.mreq;
    mem_ready       = v.mrdy;
  endtask

  task automatic idle();
    vec_t v;
    v = '{"idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0};
    set_in(v);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            name          rs1   rs2   u1 u2 rd    rw mr br mq mr  exp     st
    vecs[0]  = '{"idle",       5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, O_NONE, 2'd0};
    vecs[1]  = '{"lu_rs2",     5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, O_LU,   2'd0};
    vecs[2]  = '{"lu_rd0",     5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, O_NONE, 2'd0};
    vecs[3]  = '{"lu_rs2_off", 5'd1, 5'd5, 1, 0, 5'd5, 1, 1, 0, 0, 0, O_NONE, 2'd0};
    vecs[4]  = '{"lu_rs1",     5'd9, 5'd2, 1, 0, 5'd9, 1, 1, 0, 0, 0, O_LU,   2'd0};
    vecs[5]  = '{"alu_dep",    5'd9, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0, 0, O_NONE, 2'd0};
    vecs[6]  = '{"no_wr",      5'd9, 5'd2, 1, 1, 5'd9, 0, 1, 0, 0, 0, O_NONE, 2'd0};
    vecs[7]  = '{"br_over_lu", 5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0, 0, O_BR,   2'd0};
    vecs[8]  = '{"br",         5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, O_BR,   2'd0};
    vecs[9]  = '{"mem_hit",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, O_NONE, 2'd0};
    vecs[10] = '{"mem_wait",   5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 0, O_FRZ,  2'd0};
    vecs[11] = '{"mem_rel",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, O_BR,   2'd1};

    rst = 1'b1;
    idle();
    #2;
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(vecs[i]);
      #1;
      chk({vecs[i].name, "_outs"}, 32'(outs()), 32'(vecs[i].exp_o));
      chk({vecs[i].name, "_state"}, 32'(state_o), 32'(vecs[i].exp_st));
    end
    @(negedge clk);
    idle();
    #1;
    chk("after_rel_state", 32'(state_o), 32'd0);

    // Load-use holds for exactly one cycle: next cycle EX holds the bubble.
    @(negedge clk);
    set_in(vecs[1]);
    #1;
    chk("lu_seq_c1", 32'(outs()), 32'(O_LU));
    @(negedge clk);
    ex_mem_read  = 1'b0;
    ex_reg_write = 1'b0;
    ex_rd_addr   = 5'd0;
    #1;
    chk("lu_seq_c2", 32'(outs()), 32'(O_NONE));

    // Three wait cycles with a branch pending throughout, then release.
    idle();
    pulse_rst();
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      mem_req = 1'b1;
      mem_ready = 1'b0;
      ex_branch_taken = 1'b1;
      #1;
      chk($sformatf("wait_outs_%0d", k), 32'(outs()), 32'(O_FRZ));
      chk($sformatf("wait_state_%0d", k), 32'(state_o), (k == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rel_outs", 32'(outs()), 32'(O_BR));
    @(negedge clk);
    idle();
    #1;
    chk("rel_state", 32'(state_o), 32'd0);
    chk("rel_outs_idle", 32'(outs()), 32'(O_NONE));
`ifdef PIPELINE_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt_o, 32'd3);
    chk("flush_cnt", flush_cnt_o, 32'd1);
`endif

    // Watchdog: memory never answers.
    pulse_rst();
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      mem_req = 1'b1;
      mem_ready = 1'b0;
      #1;
      chk($sformatf("wd_outs_%0d", k), 32'(outs()), 32'(O_FRZ));
      chk($sformatf("wd_halted_%0d", k), 32'(halted_o), 32'd0);
    end
    @(negedge clk);
    mem_req = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    chk("halt_state", 32'(state_o), 32'd2);
    chk("halt_flag", 32'(halted_o), 32'd1);
    chk("halt_outs", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    #1;
    chk("halt_sticky", 32'(state_o), 32'd2);
    mem_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_halt_rst_state", 32'(state_o), 32'd0);
    chk("mid_halt_rst_halted", 32'(halted_o), 32'd0);
    chk("mid_halt_rst_outs", 32'(outs()), 32'(O_RST));
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_outs", 32'(outs()), 32'(O_NONE));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
